// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Function : Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/
//            BRANCH) with illegal-instruction pulse and saturating counter.
//            Define MC_MEM_WAIT_EN to add the MemReady wait handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  logic       Clk,
    input  logic       Rst_n,
`ifdef MC_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    input  logic [5:0] Opcode,
    input  logic [5:0] Fn,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [2:0] State,
    output logic       IllegalOp,
    output logic [7:0] IllegalCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_IDLE   = 3'd6
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_BNE   = 6'd5;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opcode;
    logic [5:0] r_fn;
    logic [7:0] r_illegal_cnt;
    logic       w_mem_ready;
    logic [4:0] w_dec_fn;
    logic [4:0] w_exec_fn;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Returns {supported, ALUOp} for an R-type function field.
    function automatic logic [4:0] rtype_decode(input logic [5:0] fn);
        case (fn)
            6'd32:   rtype_decode = 5'b1_0000;
            6'd34:   rtype_decode = 5'b1_0001;
            6'd36:   rtype_decode = 5'b1_0010;
            6'd37:   rtype_decode = 5'b1_0011;
            6'd0:    rtype_decode = 5'b1_0100;
            6'd2:    rtype_decode = 5'b1_0101;
            6'd3:    rtype_decode = 5'b1_0110;
            6'd42:   rtype_decode = 5'b1_1000;
            default: rtype_decode = 5'b0_0000;
        endcase
    endfunction

    assign w_dec_fn  = rtype_decode(Fn);
    assign w_exec_fn = rtype_decode(r_fn);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= 6'd0;
            r_fn          <= 6'd0;
            r_illegal_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_opcode <= Opcode;
                r_fn     <= Fn;
            end
            if (IllegalOp && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUOp        = 4'b0000;
        IllegalOp    = 1'b0;

        case (r_state)
            S_IDLE: w_next_state = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (w_mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            // Only DECODE looks at the live Opcode/Fn inputs.
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (((Opcode == c_OP_RTYPE) && w_dec_fn[4]) ||
                    (Opcode == c_OP_LW) || (Opcode == c_OP_SW)) begin
                    w_next_state = S_EXEC;
                end else if ((Opcode == c_OP_BEQ) || (Opcode == c_OP_BNE)) begin
                    w_next_state = S_BRANCH;
                end else begin
                    IllegalOp    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (r_opcode == c_OP_RTYPE) begin
                    ALUOp        = w_exec_fn[3:0];
                    w_next_state = S_WB;
                end else if ((r_opcode == c_OP_LW) || (r_opcode == c_OP_SW)) begin
                    ALUSrcB      = 2'b10;
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            S_MEM: begin
                if (r_opcode == c_OP_LW) begin
                    MemRead      = 1'b1;
                    w_next_state = w_mem_ready ? S_WB : S_MEM;
                end else if (r_opcode == c_OP_SW) begin
                    MemWrite     = 1'b1;
                    w_next_state = w_mem_ready ? S_FETCH : S_MEM;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            S_WB: begin
                RegWrite     = 1'b1;
                RegDst       = (r_opcode == c_OP_RTYPE);
                MemtoReg     = (r_opcode == c_OP_LW);
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 4'b0001;
                PCSource     = 2'b01;
                PCWrite      = (r_opcode == c_OP_BEQ) ? Zero :
                               (r_opcode == c_OP_BNE) ? ~Zero : 1'b0;
                w_next_state = S_FETCH;
            end

            default: w_next_state = S_IDLE;
        endcase
    end

    assign State        = r_state;
    assign IllegalCount = r_illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Function : Scoreboard bench for multicycle_controller; a per-instruction
//            reference model queues expected outputs, a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Fn = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] State;
    logic       IllegalOp;
    logic [7:0] IllegalCount;

    multicycle_controller dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
`ifdef MC_MEM_WAIT_EN
        .MemReady     (mem_ready),
`endif
        .Opcode       (Opcode),
        .Fn           (Fn),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .PCSource     (PCSource),
        .ALUOp        (ALUOp),
        .State        (State),
        .IllegalOp    (IllegalOp),
        .IllegalCount (IllegalCount)
    );

    always #5 Clk = ~Clk;

`ifdef MC_MEM_WAIT_EN
    localparam int LW_WAIT = 3;
`else
    localparam int LW_WAIT = 0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, mr, mw, rw, rd, m2r, asa;
        logic [1:0] asb, pcs;
        logic [3:0] aluop;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    int   legal_fn[8] = '{32, 34, 36, 37, 0, 2, 3, 42};

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rndz();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int rand_wait();
`ifdef MC_MEM_WAIT_EN
        return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
`else
        return 0;
`endif
    endfunction

    // Legal R-type functions take the ALU code equal to their table position; slt is 8.
    function automatic logic [4:0] r_map(input logic [5:0] fn);
        for (int i = 0; i < 8; i++) begin
            if (int'(fn) == legal_fn[i]) return {1'b1, (i == 7) ? 4'd8 : 4'(i)};
        end
        return 5'd0;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic step(input exp_t e, input logic [5:0] opc, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic rel);
        @(posedge Clk);
        #1;
        if (rel) Rst_n = 1'b1;
        Opcode    = opc;
        Fn        = fn;
        Zero      = z;
        mem_ready = rdy;
        e.cnt     = m_cnt[7:0];
        q.push_back(e);
    endtask

    // zsel: 0/1 force Zero in BRANCH, 2 random.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zsel,
                             input int fwait, input int mwait, input bit rst_mid);
        exp_t       e;
        logic [4:0] rm;
        logic       z;
        bit         is_r, is_lw, is_sw, is_br;
        rm    = r_map(fn);
        is_r  = (opc == 6'd0) && rm[4];
        is_lw = (opc == 6'd35);
        is_sw = (opc == 6'd43);
        is_br = (opc == 6'd4) || (opc == 6'd5);

        for (int i = 0; i < fwait; i++) begin
            e = mk(3'd0); e.mr = 1'b1; e.asb = 2'b01;
            step(e, rnd6(), rnd6(), rndz(), 1'b0, 1'b0);
        end
        e = mk(3'd0); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.asb = 2'b01;
        step(e, rnd6(), rnd6(), rndz(), 1'b1, 1'b0);

        e = mk(3'd1); e.asb = 2'b11; e.ill = !(is_r || is_lw || is_sw || is_br);
        step(e, opc, fn, rndz(), 1'b1, 1'b0);
        if (e.ill) begin
            if (m_cnt < 255) m_cnt++;
            return;
        end

        if (is_br) begin
            z = (zsel == 2) ? rndz() : 1'(zsel);
            e = mk(3'd5); e.asa = 1'b1; e.aluop = 4'b0001; e.pcs = 2'b01;
            e.pcw = (opc == 6'd4) ? z : !z;
            step(e, rnd6(), rnd6(), z, 1'b1, 1'b0);
            return;
        end

        e = mk(3'd2); e.asa = 1'b1;
        if (is_r) e.aluop = rm[3:0];
        else      e.asb   = 2'b10;
        step(e, rnd6(), rnd6(), rndz(), 1'b1, 1'b0);

        if (is_r) begin
            e = mk(3'd4); e.rw = 1'b1; e.rd = 1'b1;
            step(e, rnd6(), rnd6(), rndz(), 1'b1, 1'b0);
            return;
        end

        for (int i = 0; i <= mwait; i++) begin
            e = mk(3'd3); e.mr = is_lw; e.mw = is_sw;
            step(e, rnd6(), rnd6(), rndz(), (i == mwait), 1'b0);
        end

        if (rst_mid && is_sw) begin
            @(negedge Clk);
            #1 Rst_n = 1'b0;
            #1;
            chk("async_rst_state", int'(State), 6);
            chk("async_rst_memwrite", int'(MemWrite), 0);
            chk("async_rst_count", int'(IllegalCount), 0);
            m_cnt = 0;
            step(mk(3'd6), rnd6(), rnd6(), rndz(), 1'b1, 1'b0);
            step(mk(3'd6), rnd6(), rnd6(), rndz(), 1'b1, 1'b1);
            return;
        end

        if (is_lw) begin
            e = mk(3'd4); e.rw = 1'b1; e.m2r = 1'b1;
            step(e, rnd6(), rnd6(), rndz(), 1'b1, 1'b0);
        end
    endtask

    task automatic run_random(input int n);
        logic [5:0] opc, fn;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 6))
                0, 6:    opc = 6'd0;
                1:       opc = 6'd35;
                2:       opc = 6'd43;
                3:       opc = 6'd4;
                4:       opc = 6'd5;
                default: opc = rnd6();
            endcase
            fn = ($urandom_range(0, 3) != 0) ? 6'(legal_fn[$urandom_range(0, 7)]) : rnd6();
            run_instr(opc, fn, 2, rand_wait(), rand_wait(), 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                     ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, IllegalCount};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                             $time, a.st, e.st, a, e);
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) step(mk(3'd6), 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        step(mk(3'd6), 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);

        run_instr(6'd0,  6'd32, 0, 0, 0, 1'b0);
        run_instr(6'd35, 6'd0,  0, 0, LW_WAIT, 1'b0);
        run_instr(6'd43, 6'd0,  0, 0, 0, 1'b0);
        run_instr(6'd4,  6'd0,  1, 0, 0, 1'b0);
        run_instr(6'd5,  6'd0,  1, 0, 0, 1'b0);
        run_instr(6'd5,  6'd0,  0, 0, 0, 1'b0);
        run_instr(6'd4,  6'd0,  0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) run_instr(6'd0, 6'(legal_fn[i]), 0, 0, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) run_instr(6'd2, rnd6(), 0, 0, 0, 1'b0);
            else            run_instr(6'd0, 6'd55, 0, 0, 0, 1'b0);
        end
        @(negedge Clk);
        #2 chk("illegal_count_saturated", int'(IllegalCount), 255);

        run_random(150);
        run_instr(6'd43, 6'd0, 0, 0, 0, 1'b1);
        run_random(40);

        @(negedge Clk);
        #2 chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Opcode, input, 6 bits: instruction [31:26] from the instruction register.
REQ-004 SHALL have port Fn, input, 6 bits: instruction [5:0].
REQ-005 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port MemReady, input, 1 bit: memory done; present only with MC_MEM_WAIT_EN.
REQ-007 SHALL have single-bit outputs PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg and ALUSrcA.
REQ-008 SHALL have outputs ALUSrcB (2 bits), PCSource (2 bits) and ALUOp (4 bits).
REQ-009 SHALL have output State, 3 bits: current FSM state.
REQ-010 SHALL have output IllegalOp, 1 bit: single-cycle pulse on an unsupported instruction.
REQ-011 SHALL have output IllegalCount, 8 bits: saturating count of IllegalOp pulses.

Function
REQ-012 SHALL encode states as IDLE=6, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5; codes 7 and up SHALL go to IDLE.
REQ-013 SHALL drive every output not listed for a state to 0.
REQ-014 SHALL sequence IDLE for one cycle and then go to FETCH.
REQ-015 FETCH SHALL assert MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01 and ALUOp=0000, then go to DECODE.
REQ-016 DECODE SHALL register Opcode and Fn into internal copies; all later states SHALL use only these copies.
REQ-017 DECODE SHALL assert ALUSrcB=11 and ALUOp=0000 (branch target).
REQ-018 DECODE SHALL go to EXEC for Opcode 0, 35 or 43, to BRANCH for Opcode 4 or 5, and otherwise to FETCH with IllegalOp=1.
REQ-019 For Opcode 0, DECODE SHALL accept only Fn values 32, 34, 36, 37, 0, 2, 3 and 42; any other Fn SHALL be illegal (IllegalOp=1, next state FETCH).
REQ-020 EXEC for R-type SHALL assert ALUSrcA=1 and ALUSrcB=00 with ALUOp mapped from Fn: 32->0000, 34->0001, 36->0010, 37->0011, 0->0100, 2->0101, 3->0110, 42->1000; next state WB.
REQ-021 EXEC for lw/sw SHALL assert ALUSrcA=1, ALUSrcB=10 and ALUOp=0000; next state MEM.
REQ-022 MEM for lw SHALL assert MemRead=1 and go to WB; MEM for sw SHALL assert MemWrite=1 and go to FETCH.
REQ-023 WB SHALL assert RegWrite=1, with RegDst=1 and MemtoReg=0 for R-type, or RegDst=0 and MemtoReg=1 for lw; next state FETCH.
REQ-024 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=0001 and PCSource=01; next state FETCH.
REQ-025 In BRANCH, PCWrite SHALL be Zero for beq (Opcode 4) and the inverse of Zero for bne (Opcode 5), evaluated combinationally in the same cycle.
REQ-026 Instruction latency, FETCH to the next FETCH, SHALL be: R-type 4 cycles, lw 5, sw 4, beq/bne 3, illegal 2.
REQ-027 IllegalCount SHALL increment on each IllegalOp pulse and SHALL hold at 255 (no wrap).
REQ-028 Opcode/Fn changes outside DECODE SHALL NOT affect outputs, except Zero in BRANCH per REQ-025.

Reset
REQ-029 Rst_n=0 SHALL immediately force State=IDLE, all control outputs to 0, IllegalCount=0 and the internal Opcode/Fn copies to 0, including mid-instruction.
REQ-030 After Rst_n rises, the first edge SHALL go IDLE->FETCH; no write strobe (PCWrite, IRWrite, MemWrite, RegWrite) SHALL assert before FETCH.

Configuration
REQ-031 With MC_MEM_WAIT_EN defined, FETCH and MEM SHALL hold state while MemReady=0, keep MemRead/MemWrite asserted, suppress IRWrite and PCWrite, and advance on the first edge with MemReady=1.
REQ-032 Without MC_MEM_WAIT_EN, the MemReady port SHALL be absent and memory SHALL be treated as single-cycle per REQ-015 and REQ-022.

Verification
REQ-033 Reset release, then add (Opcode 0, Fn 32) -> States 6,0,1,2,4,0; ALUOp=0000 in EXEC; RegWrite=1 and RegDst=1 in WB.
REQ-034 lw (Opcode 35) -> States 0,1,2,3,4; MemRead=1 in MEM; MemtoReg=1 and RegWrite=1 in WB; sw (Opcode 43) -> MemWrite=1 in MEM, then FETCH, with RegWrite never asserted.
REQ-035 beq with Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0; bne with Zero=0 -> PCWrite=1; each takes 3 cycles.
REQ-036 Opcode 2, then Opcode 0 with Fn 55, applied 300 times -> IllegalOp pulses in DECODE and IllegalCount saturates at 255.
REQ-037 Rst_n driven low in MEM of a sw -> MemWrite drops to 0 immediately and State=6.
REQ-038 With MC_MEM_WAIT_EN, MemReady=0 for 3 cycles during lw MEM -> State holds at 3 with MemRead=1, then advances to WB.
